// File: rtl/lz4_fifo_pkg.sv
// Shared constants and helpers for the LZ4/Huffman datapath FIFOs.
package lz4_fifo_pkg;

    localparam int LZ4_FIFO_DATA_W = 47;
    localparam int LZ4_FIFO_DEPTH  = 512;

    // Smallest n such that 2**n >= value (for value >= 1).
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/lz4_sdp_ram.sv
// Simple dual-port RAM: port A write-only, port B read-only with a registered read.
// Only the read output register is reset; the array itself is never cleared.
module lz4_sdp_ram
    import lz4_fifo_pkg::*;
#(
    parameter  int DATA_W = LZ4_FIFO_DATA_W,
    parameter  int DEPTH  = LZ4_FIFO_DEPTH,
    localparam int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/lz4_sync_fifo.sv
// Single-clock FIFO with registered flags, overflow/underflow pulses and a head/bypass stage.
// Define LZ4_FIFO_FWFT_EN for first-word-fall-through; otherwise standard 1-cycle read timing.
module lz4_sync_fifo
    import lz4_fifo_pkg::*;
#(
    parameter int DATA_W   = LZ4_FIFO_DATA_W,
    parameter int DEPTH    = LZ4_FIFO_DEPTH,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4
) (
    input  logic                     clk,
    input  logic                     rstN,
    input  logic [DATA_W-1:0]        din,
    input  logic                     wr_en,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        dout,
    output logic                     valid,
    output logic                     empty,
    output logic                     full,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [clog2(DEPTH):0]    data_count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic              empty_reg, full_reg, af_reg, ae_reg;
    logic              overflow_reg, underflow_reg;
    logic              wr_accept, rd_accept;
    logic              ram_re;
    logic [AW-1:0]     ram_raddr;
    logic [DATA_W-1:0] ram_rdata;

    assign wr_accept = wr_en && !full_reg;
    assign rd_accept = rd_en && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({wr_accept, rd_accept})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Flags are derived from the next count so they always agree with data_count.
    always_ff @(posedge clk) begin
        if (!rstN) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            empty_reg     <= 1'b1;
            full_reg      <= 1'b0;
            af_reg        <= 1'b0;
            ae_reg        <= 1'b1;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg     <= count_next;
            empty_reg     <= (count_next == '0);
            full_reg      <= (count_next == FULL_CNT);
            af_reg        <= (count_next >= AF_CNT);
            ae_reg        <= (count_next <= AE_CNT);
            overflow_reg  <= wr_en && full_reg;
            underflow_reg <= rd_en && empty_reg;
        end
    end

    lz4_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .rstN  (rstN),
        .we    (wr_accept),
        .waddr (wr_ptr_reg),
        .wdata (din),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

`ifdef LZ4_FIFO_FWFT_EN
    logic [DATA_W-1:0] head_reg;
    logic              bypass_reg;
    logic              bypass_load;

    // A word written into an otherwise-empty head slot cannot come back through
    // the RAM in time, so it is captured directly from din for one cycle.
    assign bypass_load = wr_accept && (empty_reg || (rd_accept && count_reg == CW'(1)));

    // Prefetch: the RAM always reads the address that will be the head next cycle.
    assign ram_re    = 1'b1;
    assign ram_raddr = rd_accept ? rd_ptr_reg + 1'b1 : rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            head_reg   <= '0;
            bypass_reg <= 1'b0;
        end else begin
            bypass_reg <= bypass_load;
            if (bypass_load) begin
                head_reg <= din;
            end
        end
    end

    assign valid = !empty_reg;
    assign dout  = empty_reg ? '0 : (bypass_reg ? head_reg : ram_rdata);
`else
    logic valid_reg;

    assign ram_re    = rd_accept;
    assign ram_raddr = rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (!rstN) begin
            valid_reg <= 1'b0;
        end else begin
            valid_reg <= rd_accept;
        end
    end

    assign valid = valid_reg;
    assign dout  = ram_rdata;
`endif

    assign empty        = empty_reg;
    assign full         = full_reg;
    assign almost_full  = af_reg;
    assign almost_empty = ae_reg;
    assign data_count   = count_reg;
    assign overflow     = overflow_reg;
    assign underflow    = underflow_reg;

endmodule

// File: tb/tb_lz4_sync_fifo.sv
// Randomised self-checking bench for lz4_sync_fifo against a queue-based FIFO model.
module tb_lz4_sync_fifo;
    import lz4_fifo_pkg::*;

    localparam int DATA_W   = LZ4_FIFO_DATA_W;
    localparam int DEPTH    = LZ4_FIFO_DEPTH;
    localparam int AF_LEVEL = DEPTH - 4;
    localparam int AE_LEVEL = 4;
    localparam int CW       = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rstN;
    logic [DATA_W-1:0] din;
    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] dout;
    logic              valid;
    logic              empty;
    logic              full;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     data_count;
    logic              overflow;
    logic              underflow;

    always #5 clk = ~clk;

    lz4_sync_fifo #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AF_LEVEL),
        .AE_LEVEL (AE_LEVEL)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .din          (din),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .dout         (dout),
        .valid        (valid),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .data_count   (data_count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    int                n_checks = 0;
    int                n_pass   = 0;
    logic [DATA_W-1:0] model_q[$];
    logic [DATA_W-1:0] last_read;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs(input logic exp_ovf, input logic exp_udf, input logic exp_valid,
                                 input logic chk_dout, input logic [DATA_W-1:0] exp_dout);
        int occ;
        occ = model_q.size();
        check_val("count", 64'(data_count), 64'(occ));
        check_val("empty", 64'(empty), 64'(occ == 0));
        check_val("full", 64'(full), 64'(occ == DEPTH));
        check_val("almost_full", 64'(almost_full), 64'(occ >= AF_LEVEL));
        check_val("almost_empty", 64'(almost_empty), 64'(occ <= AE_LEVEL));
        check_val("overflow", 64'(overflow), 64'(exp_ovf));
        check_val("underflow", 64'(underflow), 64'(exp_udf));
        check_val("valid", 64'(valid), 64'(exp_valid));
        if (chk_dout) begin
            check_val("dout", 64'(dout), 64'(exp_dout));
        end
    endtask

    // One clock of traffic: model decides acceptance from its own occupancy.
    task automatic cycle(input logic wr, input logic rd, input logic [DATA_W-1:0] data);
        int                occ;
        logic              wacc, racc, exp_valid, chk_dout;
        logic [DATA_W-1:0] exp_dout;
        wr_en = wr;
        rd_en = rd;
        din   = data;
        occ   = model_q.size();
        wacc  = wr && (occ < DEPTH);
        racc  = rd && (occ > 0);
        @(posedge clk);
        #1;
        if (racc) begin
            last_read = model_q.pop_front();
        end
        if (wacc) begin
            model_q.push_back(data);
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
`ifdef LZ4_FIFO_FWFT_EN
        exp_valid = (model_q.size() > 0);
        chk_dout  = exp_valid;
        exp_dout  = exp_valid ? model_q[0] : '0;
`else
        exp_valid = racc;
        chk_dout  = 1'b1;
        exp_dout  = last_read;
`endif
        check_outputs(wr && occ == DEPTH, rd && occ == 0, exp_valid, chk_dout, exp_dout);
    endtask

    task automatic do_reset(input logic wr, input logic rd);
        rstN  = 1'b0;
        wr_en = wr;
        rd_en = rd;
        din   = 47'h5A5A_5A5A_5A5A;
        @(posedge clk);
        #1;
        rstN  = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        model_q.delete();
        last_read = '0;
        check_outputs(1'b0, 1'b0, 1'b0, 1'b1, '0);
    endtask

    function automatic logic [DATA_W-1:0] rand_word();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[DATA_W-1:0];
    endfunction

    initial begin
        rstN      = 1'b0;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        din       = '0;
        last_read = '0;

        do_reset(1'b0, 1'b0);

        // Single word in and out.
        cycle(1'b1, 1'b0, DATA_W'(1));
        cycle(1'b0, 1'b1, '0);

        // Fill to full, overflow, full read+write, drain in order.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1'b1, 1'b0, DATA_W'(i));
        end
        cycle(1'b1, 1'b0, DATA_W'(999));
        cycle(1'b1, 1'b1, DATA_W'(777));
        for (int i = 0; i <= DEPTH && model_q.size() > 0; i++) begin
            cycle(1'b0, 1'b1, '0);
        end

        // Underflow on empty, then simultaneous read+write on empty.
        cycle(1'b0, 1'b1, '0);
        cycle(1'b1, 1'b1, DATA_W'(16'h4242));

        // Occupancy 1 streaming through the pointer wrap.
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b1, 1'b1, DATA_W'(i + 1000));
        end
        cycle(1'b0, 1'b1, '0);

        // Short read/hold sequence.
        cycle(1'b1, 1'b0, DATA_W'(4'hA));
        cycle(1'b1, 1'b0, DATA_W'(4'hB));
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        // Random traffic with varying write/read bias.
        for (int blk = 0; blk < 8; blk++) begin
            int pw, pr;
            pw = int'($urandom_range(10, 95));
            pr = int'($urandom_range(10, 95));
            for (int i = 0; i < 500; i++) begin
                cycle(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), rand_word());
            end
        end

        // Reset mid-transfer at occupancy 300, then verify no stale data.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 300; i++) begin
            cycle(1'b1, 1'b0, rand_word());
        end
        do_reset(1'b1, 1'b1);
        cycle(1'b1, 1'b0, DATA_W'(16'h1234));
        cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, '0);
        cycle(1'b0, 1'b0, '0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/lz4_sync_fifo.md
# lz4_sync_fifo

Parametrised single-clock FIFO for the LZ4/Huffman datapath. It is the generic successor to the fixed 512-entry BRAM FIFOs between the match finder, sequence packer and Huffman encoder. It adds configurable width and depth, almost-full and almost-empty thresholds, overflow and underflow flags, and a compile-time choice between first-word-fall-through and standard read timing. Storage is a synchronous-read simple dual-port RAM with a head register in front of it.

## Interface
- `DATA_W`, default 47: word width in bits.
- `DEPTH`, default 512: entries. Must be a power of two, ≥ 4.
- `AF_LEVEL`, default `DEPTH-4`: `almost_full` asserts when count ≥ this value.
- `AE_LEVEL`, default 4: `almost_empty` asserts when count ≤ this value.
- `clk`, input, 1: the single clock. All logic is on the rising edge.
- `rstN`, input, 1: reset. Synchronous, active-low.
- `din`, input, `DATA_W`: write data.
- `wr_en`, input, 1: write request.
- `rd_en`, input, 1: read (pop) request.
- `dout`, output, `DATA_W`: read data.
- `valid`, output, 1: `dout` holds a real word (meaning depends on the mode; see Configuration).
- `empty`, output, 1: occupancy is 0.
- `full`, output, 1: occupancy equals `DEPTH`.
- `almost_full`, output, 1: occupancy ≥ `AF_LEVEL`.
- `almost_empty`, output, 1: occupancy ≤ `AE_LEVEL`.
- `data_count`, output, `$clog2(DEPTH)+1`: current occupancy.
- `overflow`, output, 1: one-cycle pulse when a write is dropped.
- `underflow`, output, 1: one-cycle pulse when a read is ignored.

## Operation
- A write is accepted iff `wr_en` and `!full` in that cycle.
- A read is accepted iff `rd_en` and `!empty` in that cycle.
- All flags and the count are registered. They update on the edge that follows an accepted operation and always agree with `data_count`.
- Count update:
  - Accepted write only: count +1.
  - Accepted read only: count −1.
  - Both accepted: count unchanged.
- Write while full: the word is dropped, pointers do not move, `overflow`=1 for one cycle.
- Read while empty: ignored, `underflow`=1 for one cycle.
- `wr_en` and `rd_en` together while full: only the read is accepted. Count becomes `DEPTH-1`, `overflow` pulses.
- `wr_en` and `rd_en` together while empty: only the write is accepted. Count becomes 1, `underflow` pulses.
- Pointers are `$clog2(DEPTH)` bits wide and wrap naturally from `DEPTH-1` to 0. Data order is preserved across the wrap.
- Head register: when the FIFO is empty, or when the head is being consumed with nothing left in RAM, an incoming write loads the head register directly from `din` (bypass). Otherwise the head is refilled from RAM using the prefetched next address.
- Reset, at any time including mid-transfer:
  - pointers 0, count 0, `dout`=0, `valid`=0;
  - `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0;
  - `overflow`=0, `underflow`=0.
  - RAM contents are not cleared, and no stale word is ever presented after reset.

## Timing
- FWFT mode, write into an empty FIFO at edge k: after edge k+1, `empty`=0, `valid`=1 and `dout`=that word.
- FWFT mode, back-to-back reads: one word per cycle with no bubbles, provided occupancy ≥ 1 at every read.
- Standard mode read latency: an accepted read at edge k presents data on `dout` with `valid`=1 for exactly one cycle after edge k+1.
- Standard mode, between reads: `dout` holds the last word read.
- Flag latency: 1 cycle after the causing edge, in both modes.
- Sustained throughput: 1 write and 1 read per cycle at any occupancy other than full or empty.

## Configuration
- `LZ4_FIFO_FWFT_EN` defined (FWFT mode):
  - `dout` always shows the head word; `valid` = `!empty`.
  - `rd_en` acknowledges and pops the current `dout`.
- `LZ4_FIFO_FWFT_EN` undefined (standard mode):
  - `rd_en` requests the next word, which appears one cycle later with a one-cycle `valid` pulse.
  - The head register is bypassed, and `dout` is driven from the RAM output register.
- Flag, count, overflow and underflow behaviour is identical in both modes.

## Structure
- Package `lz4_fifo_pkg`: a `clog2` helper function and default constants `LZ4_FIFO_DATA_W`=47 and `LZ4_FIFO_DEPTH`=512.
- Sub-module `lz4_sdp_ram`, parametrised by `DATA_W` and `DEPTH`: port A write-only, port B read-only, registered read (1-cycle latency), no reset on the array.
- The top level holds pointers, count, flags, the head/bypass register, the prefetch addressing and the mode selection.

## Test plan
- Defaults, FWFT mode. Write 0x1 at edge 0 → after edge 1: `empty`=0, `dout`=0x1, `valid`=1. Pop at edge 2 → `empty`=1, count 0.
- Fill with 512 writes of values 0..511 → `full`=1, count 512, `almost_full`=1 from count 508. One extra write → `overflow` pulses, count stays 512. Reading all 512 returns 0..511 in order.
- Occupancy 1, simultaneous `wr_en`/`rd_en` for 1000 cycles with an incrementing pattern → count stays 1, output sequence is gap-free, pointers wrap at least once.
- Empty FIFO, `rd_en`=1 → `underflow` pulses, count 0, `valid`=0. Full FIFO, `wr_en`+`rd_en` → count 511, `overflow` pulses.
- Standard mode (macro undefined). Write 0xA, 0xB, then `rd_en` at edge k → `dout`=0xA with `valid`=1 for only cycle k+1. `dout` holds 0xA until the next read.
- `rstN`=0 for one edge while count is 300 → all outputs reach their reset values. The first write afterwards reads back correctly, with no stale data.
